// File: rtl/rs232_tx_packet_pkg.sv
// Shared constants and helpers for the RS-232 packet transmitter.
// Holds the frame delimiters, the bit timing and the payload byte offsets
// that the receiver uses for the same frame. It also provides the byte-mux
// function that maps a frame byte index to the byte on the wire.
package rs232_tx_packet_pkg;

    localparam int        DEF_CLKS_PER_BIT  = 47;
    localparam int        CLKS_PER_1_5_BIT  = 70;   // receiver mid-bit sampling offset
    localparam int        FRAME_BYTES       = 8;
    localparam logic [7:0] DEF_STX          = 8'h02;
    localparam logic [7:0] DEF_ETX          = 8'h03;
    localparam logic [7:0] DEF_RSP_TAG      = 8'h00;

    // Payload byte offsets inside the 8-byte frame, little-endian word.
    localparam logic [2:0] PAYLOAD_OFS_0    = 3'd2;
    localparam logic [2:0] PAYLOAD_OFS_1    = 3'd3;
    localparam logic [2:0] PAYLOAD_OFS_2    = 3'd4;
    localparam logic [2:0] PAYLOAD_OFS_3    = 3'd5;

    // 13 bits covers CLKS_PER_BIT values up to 8191.
    localparam int        TIMER_W           = 13;

    // Byte on the wire for frame position idx.
    function automatic logic [7:0] frame_byte(
        input logic [2:0]  idx,
        input logic [31:0] word,
        input logic [7:0]  stx,
        input logic [7:0]  tag,
        input logic [7:0]  etx
    );
        logic [7:0] b;
        case (idx)
            3'd0:          b = stx;
            3'd1:          b = tag;
            PAYLOAD_OFS_0: b = word[7:0];
            PAYLOAD_OFS_1: b = word[15:8];
            PAYLOAD_OFS_2: b = word[23:16];
            PAYLOAD_OFS_3: b = word[31:24];
            3'd6:          b = 8'h00;
            default:       b = etx;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rs232_tx_packet_uart_tx_byte.sv
// uart_tx_byte: serializes one 8N1 byte, LSB first.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   start      - load din and begin a byte (honoured only while ready=1)
//   din[7:0]   - byte to send
//   tx         - registered serial output, idle high
//   ready      - high when a start in this cycle is accepted: either idle,
//                or in the last cycle of the stop bit, which lets the next
//                byte follow the stop bit with no gap.
module uart_tx_byte
    import rs232_tx_packet_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    logic [1:0]         state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [2:0]         bit_idx_reg, bit_idx_next;
    logic [7:0]         shift_reg, shift_next;
    logic               tx_reg, tx_next;
    logic               timer_done;

    assign timer_done = (timer_reg == TIMER_LAST);
    assign ready      = (state_reg == S_IDLE) || ((state_reg == S_STOP) && timer_done);
    assign tx         = tx_reg;

    // tx_next is the value the line takes in the next cycle, so every
    // transition is computed one cycle early and the pin stays registered.
    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;

        if (state_reg != S_IDLE) begin
            timer_next = timer_done ? '0 : timer_reg + TIMER_W'(1);
        end

        case (state_reg)
            S_IDLE: begin
                tx_next    = 1'b1;
                timer_next = '0;
                if (start) begin
                    state_next = S_START;
                    shift_next = din;
                    tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (timer_done) begin
                    state_next   = S_DATA;
                    bit_idx_next = 3'd0;
                    tx_next      = shift_reg[0];
                end
            end
            S_DATA: begin
                if (timer_done) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        tx_next      = shift_reg[1];
                    end
                end
            end
            S_STOP: begin
                if (timer_done) begin
                    if (start) begin
                        state_next = S_START;
                        shift_next = din;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
        end
    end

endmodule

// File: rtl/rs232_tx_packet.sv
// rs232_tx_packet: sends a 32-bit read word to the host as one 8-byte UART
// frame: STX, RSP_TAG, word bytes LSB first, 0x00, ETX.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   tx_start   - one-cycle request; accepted only while busy=0
//   tx_data    - 32-bit word, captured in the accepting cycle
//   tx         - serial line, idle high
//   busy       - high for the whole frame, 8*10*CLKS_PER_BIT cycles
//   drop       - one-cycle pulse after a request that arrived while busy
module rs232_tx_packet
    import rs232_tx_packet_pkg::*;
#(
    parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter logic [7:0] STX          = DEF_STX,
    parameter logic [7:0] ETX          = DEF_ETX,
    parameter logic [7:0] RSP_TAG      = DEF_RSP_TAG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [31:0] tx_data,
    output logic        tx,
    output logic        busy,
    output logic        drop
);

    localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

    logic        busy_reg;
    logic        drop_reg;
    logic [2:0]  byte_idx_reg;
    logic [31:0] data_reg;

    logic        accept;
    logic        ser_start;
    logic [7:0]  ser_din;
    logic        ser_ready;

    assign accept = tx_start && !busy_reg;
    assign busy   = busy_reg;
    assign drop   = drop_reg;

    // The first byte is fed straight from the accept so the start bit
    // appears in the cycle after acceptance. Later bytes come from the
    // latched word, handed over in the last stop-bit cycle of the previous
    // byte so bytes run back to back.
    always_comb begin
        ser_start = 1'b0;
        ser_din   = STX;
        if (accept) begin
            ser_start = 1'b1;
            ser_din   = STX;
        end else if (busy_reg && ser_ready && (byte_idx_reg != LAST_BYTE)) begin
            ser_start = 1'b1;
            ser_din   = frame_byte(byte_idx_reg + 3'd1, data_reg, STX, RSP_TAG, ETX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg     <= 1'b0;
            drop_reg     <= 1'b0;
            byte_idx_reg <= '0;
            data_reg     <= '0;
        end else begin
            drop_reg <= tx_start && busy_reg;
            if (accept) begin
                busy_reg     <= 1'b1;
                byte_idx_reg <= '0;
                data_reg     <= tx_data;
            end else if (busy_reg && ser_ready) begin
                if (byte_idx_reg == LAST_BYTE) begin
                    busy_reg <= 1'b0;
                end else begin
                    byte_idx_reg <= byte_idx_reg + 3'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (ser_start),
        .din   (ser_din),
        .tx    (tx),
        .ready (ser_ready)
    );

endmodule

// File: tb/tb_rs232_tx_packet.sv
// Self-checking bench for rs232_tx_packet: a UART monitor decodes the line
// and pops expected bytes from a scoreboard queue filled at request time.
module tb_rs232_tx_packet;

    localparam int CPB       = 47;
    localparam int FRAME_CYC = 8 * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_start = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx;
    logic        busy;
    logic        drop;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int rx_count = 0;
    int frames_done = 0;
    int last_busy_len = 0;

    rs232_tx_packet dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .busy     (busy),
        .drop     (drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [31:0] d);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h00);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h03);
    endtask

    // UART receiver: samples each bit in its middle, counted from the
    // first low cycle of the start bit.
    int         mon_cnt = 0;
    bit         mon_active = 0;
    logic [7:0] mon_byte = '0;
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (tx == 1'b0) begin
                mon_active = 1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == CPB / 2) begin
                check("start_bit", tx, 1'b0);
            end else if (mon_cnt > CPB / 2 && mon_cnt <= CPB / 2 + 8 * CPB
                         && (mon_cnt - CPB / 2) % CPB == 0) begin
                mon_byte = {tx, mon_byte[7:1]};
            end else if (mon_cnt == CPB / 2 + 9 * CPB) begin
                check("stop_bit", tx, 1'b1);
                check("rx_expected_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("rx_byte", mon_byte, exp_q.pop_front());
                rx_count++;
                mon_active = 0;
            end
        end
    end

    // Frame timing: busy length and line transitions only on bit boundaries.
    int   fstart = 0;
    int   busy_run = 0;
    logic prev_busy = 0;
    logic prev_tx = 1;
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 0;
            prev_tx = 1;
            busy_run = 0;
        end else begin
            if (busy && !prev_busy) begin
                fstart = cyc;
                busy_run = 0;
            end
            if (busy) busy_run++;
            if (!busy && prev_busy) begin
                last_busy_len = busy_run;
                frames_done++;
            end
            if (busy && prev_busy && tx !== prev_tx)
                check("bit_edge_phase", (cyc - fstart) % CPB, 0);
            prev_busy = busy;
            prev_tx = tx;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic request(input logic [31:0] d, input bit expect_accept);
        tx_start = 1'b1;
        tx_data  = d;
        if (expect_accept) push_frame(d);
        $display("request data=%08h expect_accept=%0d cycle=%0d", d, expect_accept, cyc);
        tick(1);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            tick(1);
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic finish_frame(input int rx_before, input int frames_before);
        wait_idle(FRAME_CYC + 100);
        tick(2);
        check("busy_len", last_busy_len, FRAME_CYC);
        check("frame_count", frames_done - frames_before, 1);
        check("frame_rx_bytes", rx_count - rx_before, 8);
        check("queue_drained", exp_q.size(), 0);
        check("idle_tx", tx, 1'b1);
    endtask

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0;
        int fr0;
        int low;

        // Reset and idle line
        rst = 1'b1;
        tick(5);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop, 1'b0);
        rst = 1'b0;
        low = 0;
        repeat (1000) begin
            tick(1);
            if (tx !== 1'b1 || busy !== 1'b0) low++;
        end
        check("idle_line_high", low, 0);

        // Single frame, accept timing
        rx0 = rx_count; fr0 = frames_done;
        request(32'hDEADBEEF, 1);
        check("accept_busy", busy, 1'b1);
        check("accept_tx_start_bit", tx, 1'b0);
        finish_frame(rx0, fr0);

        // tx_data changes after capture are ignored
        rx0 = rx_count; fr0 = frames_done;
        request(32'hDEADBEEF, 1);
        tx_data = 32'h0;
        tick(300);
        tx_data = $urandom;
        finish_frame(rx0, fr0);

        // Collision at cycle n+500
        rx0 = rx_count; fr0 = frames_done;
        request(32'h11223344, 1);
        tick(499);
        request(32'h12345678, 0);
        check("drop_pulse", drop, 1'b1);
        tick(1);
        check("drop_single", drop, 1'b0);
        finish_frame(rx0, fr0);
        tick(1000);
        check("no_second_frame_rx", rx_count - rx0, 8);
        check("no_second_frame_busy", busy, 1'b0);

        // Back-to-back: request in the first cycle busy reads 0
        rx0 = rx_count; fr0 = frames_done;
        request(32'hA5A55A5A, 1);
        wait_idle(FRAME_CYC + 100);
        request(32'h0F1E2D3C, 1);
        check("b2b_busy", busy, 1'b1);
        check("b2b_tx", tx, 1'b0);
        check("b2b_first_len", last_busy_len, FRAME_CYC);
        check("b2b_first_rx", rx_count - rx0, 8);
        finish_frame(rx0 + 8, fr0 + 1);

        // Reset mid-frame at cycle n+1200
        request(32'h87654321, 1);
        tick(1199);
        rst = 1'b1;
        tick(1);
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        tick(5);
        check("midrst_stays_idle", busy, 1'b0);
        rx0 = rx_count; fr0 = frames_done;
        request(32'h0BADC0DE, 1);
        finish_frame(rx0, fr0);

        // Loopback read response for RAM[5]
        rx0 = rx_count; fr0 = frames_done;
        request(32'hCAFEF00D, 1);
        finish_frame(rx0, fr0);

        tick(10);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs232_tx_packet.md
Name: rs232_tx_packet

Overview:
- Downstream stage of the RS-232 packet receiver.
- On a read request, the receiver pulses tx_start one cycle after the RAM read, with the 32-bit read word on ram_out. This block captures that word and transmits it to the host as one 8-byte UART frame.
- The frame uses the same format the receiver accepts: STX 0x02 first, ETX 0x03 last, 8N1, LSB-first.
- Drives the board TX pin; the host link stays half-duplex by protocol.

Parameters:
- CLKS_PER_BIT, 47, clocks per UART bit; matches the receiver's 1-bit delay (count 0..46).
- STX, 8'h02, first frame byte.
- ETX, 8'h03, last frame byte.
- RSP_TAG, 8'h00, byte 1 of the frame; bit7=0 marks a read response.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_start  in  1  one-cycle request pulse from the receiver
- tx_data  in  32  read word (receiver ram_out); valid in the tx_start cycle
- tx  out  1  serial line; idle high
- busy  out  1  high while a frame is in flight
- drop  out  1  one-cycle pulse when tx_start arrives while busy

Behaviour:
- Reset values: tx=1, busy=0, drop=0, FSM=IDLE, all counters 0, data register 0. Reset wins over every other event, including mid-frame: tx=1 and busy=0 on the next edge, and the partial frame is abandoned.
- Frame bytes, in order:
  - b0 = STX
  - b1 = RSP_TAG
  - b2 = tx_data[7:0]
  - b3 = tx_data[15:8]
  - b4 = tx_data[23:16]
  - b5 = tx_data[31:24]
  - b6 = 8'h00
  - b7 = ETX
  - This matches the receiver's layout: payload at byte offsets 2..5.
- Each byte: start bit 0, eight data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles. There is no extra gap between bytes.
- Accept rule: tx_start sampled high at edge n while busy=0:
  - tx_data latched at edge n; later changes on tx_data are ignored.
  - busy=1 and tx=0 (b0 start bit) from cycle n+1.
- Frame length is 8*10*CLKS_PER_BIT cycles (3760 at default). busy stays high for cycles n+1..n+3760 and is low from n+3761, with tx=1.
- tx_start while busy=1 is ignored: drop=1 for exactly one cycle, and the in-flight frame is unaffected. Acceptance is legal again in the first cycle busy reads 0.
- FSM states:
  - IDLE: tx=1. Go to START on accept.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0], 8 bits; bit counter 0..7, shifted each bit period. Then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_idx==7, go to IDLE with busy=0. Otherwise byte_idx+1, load the next byte, go to START.
- Counter widths:
  - Bit-timer is 13 bits, wide enough for CLKS_PER_BIT up to 8191; wraps to 0 at CLKS_PER_BIT-1.
  - byte_idx is 3 bits.
  - bit_idx is 3 bits.
- tx is driven from a register (glitch-free). Combinational next-state and outputs use default assignments.

Decomposition:
- Shared include file (rs232_defs.vh) holds:
  - STX, ETX, CLKS_PER_BIT, CLKS_PER_1_5_BIT (70), FRAME_BYTES (8).
  - Payload byte offset constants (2..5).
- Receiver and transmitter both include it.
- Natural sub-module: uart_tx_byte.
  - Ports: clk, rst, start, din[7:0], tx, ready.
  - Serializes one 8N1 byte.
  - rs232_tx_packet keeps the byte index, the byte mux and the busy/drop logic.

Test Plan:
- Reset check: rst held 5 cycles -> tx=1, busy=0, drop=0; tx stays 1 for 1000 idle cycles.
- Single frame: tx_start with tx_data=32'hDEADBEEF -> UART monitor decodes bytes 02 00 EF BE AD DE 00 03; busy=1 for exactly 3760 cycles.
- Bit timing: the same frame with tx_data changed after the tx_start cycle -> every bit is exactly 47 cycles; transmitted bytes still match the latched value.
- Busy collision: second tx_start (32'h12345678) at cycle n+500 -> drop pulses 1 cycle; the first frame is unchanged; no second frame follows.
- Back-to-back: tx_start in the first cycle busy=0 -> second frame starts next cycle with no idle gap beyond the stop bit.
- Reset mid-frame: rst at cycle n+1200 -> tx=1 and busy=0 the next cycle. A new request afterward transmits a complete, correct frame.
- Loopback: the receiver sends a read packet (02, addr 0x05, read) after RAM[5]=32'hCAFEF00D -> this block emits 02 00 0D F0 FE CA 00 03.
